// File: rtl/hf_defs.sv
// Shared definitions for the HF configuration receiver/scheduler.
// Holds the ARM command opcode, the major-mode encodings, the reset
// configuration word and the sequencer state type.
package hf_defs;

  localparam logic [3:0] FPGA_CMD_SET_CONFREG = 4'b0001;

  localparam logic [2:0] MODE_HI_READ_TX       = 3'd0;
  localparam logic [2:0] MODE_HI_READ_RX_XCORR = 3'd1;
  localparam logic [2:0] MODE_HI_SIMULATE      = 3'd2;
  localparam logic [2:0] MODE_HI_ISO14443A     = 3'd3;
  localparam logic [2:0] MODE_HI_SNIFFER       = 3'd4;
  localparam logic [2:0] MODE_OFF              = 3'd7;

  localparam logic [7:0] CONF_RESET_WORD = 8'hE0;

  typedef enum logic {
    ST_IDLE,
    ST_GUARD
  } sched_state_t;

  function automatic logic is_set_confreg(input logic [3:0] opcode);
    return opcode == FPGA_CMD_SET_CONFREG;
  endfunction

endpackage

// File: rtl/spi_oversample_rx.sv
// SPI frame receiver oversampled in the carrier clock domain.
// Ports:
//   clk        - carrier clock (ck_1356meg)
//   rst        - synchronous active-high reset
//   spck/mosi/ncs - asynchronous SPI pins from the ARM
//   frame_done - one-cycle pulse after a synced ncs rising edge (armed only)
//   frame_ok   - frame held exactly 16 bits (valid with frame_done)
//   frame_word - received 16-bit frame (valid with frame_done)
module spi_oversample_rx
  import hf_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        spck,
  input  logic        mosi,
  input  logic        ncs,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [15:0] frame_word
);

  logic [1:0]  spck_sync;
  logic [1:0]  mosi_sync;
  logic [1:0]  ncs_sync;
  logic        spck_d;
  logic        ncs_d;
  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt;
  logic        armed;

  logic spck_s;
  logic mosi_s;
  logic ncs_s;

  assign spck_s = spck_sync[1];
  assign mosi_s = mosi_sync[1];
  assign ncs_s  = ncs_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      spck_sync  <= '0;
      mosi_sync  <= '0;
      ncs_sync   <= '0;
      spck_d     <= 1'b0;
      ncs_d      <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      armed      <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      frame_word <= '0;
    end else begin
      spck_sync <= {spck_sync[0], spck};
      mosi_sync <= {mosi_sync[0], mosi};
      ncs_sync  <= {ncs_sync[0], ncs};
      spck_d    <= spck_s;
      ncs_d     <= ncs_s;

      // Arming uses the previous value, so a frame straddling reset
      // release ends before armed can be seen and is dropped silently.
      if (ncs_s) armed <= 1'b1;

      frame_done <= armed & ncs_s & ~ncs_d;
      frame_ok   <= (bit_cnt == 5'd16);
      frame_word <= shift_reg;

      if (!ncs_s && ncs_d) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (!ncs_s && spck_s && !spck_d) begin
        shift_reg <= {shift_reg[14:0], mosi_s};
        if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

endmodule

// File: rtl/hf_conf_sched.sv
// HF configuration receiver and guarded major-mode sequencer.
// Decodes SET_CONFREG frames from the ARM and applies them; changes of
// major mode pass through GUARD_CYCLES of MODE_OFF so the mode muxes
// never hop directly between two active modes.
// Ports:
//   ck_1356meg    - sole clock (13.56 MHz carrier)
//   rst           - synchronous active-high reset
//   spck/mosi/ncs - asynchronous SPI pins from the ARM
//   conf_word     - applied configuration word
//   major_mode    - applied major mode (conf_word[7:5] outside guard)
//   switching     - guarded major-mode change in progress
//   frame_err_cnt - saturating count of wrong-length frames
module hf_conf_sched
  import hf_defs::*;
#(
  parameter int unsigned GUARD_CYCLES = 64,
  parameter int unsigned ERR_W        = 4
) (
  input  logic             ck_1356meg,
  input  logic             rst,
  input  logic             spck,
  input  logic             mosi,
  input  logic             ncs,
  output logic [7:0]       conf_word,
  output logic [2:0]       major_mode,
  output logic             switching,
  output logic [ERR_W-1:0] frame_err_cnt
);

  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

  logic        frame_done;
  logic        frame_ok;
  logic [15:0] frame_word;

  spi_oversample_rx u_rx (
    .clk        (ck_1356meg),
    .rst        (rst),
    .spck       (spck),
    .mosi       (mosi),
    .ncs        (ncs),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .frame_word (frame_word)
  );

  sched_state_t     state, state_n;
  logic [7:0]       pending, pending_n;
  logic [7:0]       guard_cnt, guard_n;
  logic [7:0]       conf_n;
  logic [2:0]       major_n;
  logic             switching_n;
  logic [ERR_W-1:0] err_n;

  logic       valid;
  logic [7:0] new_word;
  logic       unused_rsvd;

  assign valid       = frame_done & frame_ok & is_set_confreg(frame_word[15:12]);
  assign new_word    = frame_word[7:0];
  assign unused_rsvd = ^frame_word[11:8];

  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      state         <= ST_IDLE;
      pending       <= '0;
      guard_cnt     <= '0;
      conf_word     <= CONF_RESET_WORD;
      major_mode    <= MODE_OFF;
      switching     <= 1'b0;
      frame_err_cnt <= '0;
    end else begin
      state         <= state_n;
      pending       <= pending_n;
      guard_cnt     <= guard_n;
      conf_word     <= conf_n;
      major_mode    <= major_n;
      switching     <= switching_n;
      frame_err_cnt <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    pending_n   = pending;
    guard_n     = guard_cnt;
    conf_n      = conf_word;
    major_n     = major_mode;
    switching_n = switching;
    err_n       = frame_err_cnt;

    if (frame_done && !frame_ok && frame_err_cnt != '1)
      err_n = frame_err_cnt + 1'b1;

    unique case (state)
      ST_IDLE: begin
        if (valid) begin
          if (new_word[7:5] == major_mode || new_word[7:5] == MODE_OFF) begin
            conf_n  = new_word;
            major_n = new_word[7:5];
          end else begin
            pending_n   = new_word;
            major_n     = MODE_OFF;
            guard_n     = GUARD_LOAD;
            switching_n = 1'b1;
            state_n     = ST_GUARD;
          end
        end
      end
      ST_GUARD: begin
        // A fresh target restarts the guard; MODE_OFF needs no guard.
        if (valid && new_word[7:5] == MODE_OFF) begin
          conf_n      = new_word;
          major_n     = MODE_OFF;
          switching_n = 1'b0;
          state_n     = ST_IDLE;
        end else if (valid) begin
          pending_n = new_word;
          guard_n   = GUARD_LOAD;
        end else if (guard_cnt == '0) begin
          conf_n      = pending;
          major_n     = pending[7:5];
          switching_n = 1'b0;
          state_n     = ST_IDLE;
        end else begin
          guard_n = guard_cnt - 8'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hf_conf_sched.sv
// Self-checking bench for hf_conf_sched: directed timing sequences,
// a table of frames with settled expectations, and randomized frames
// checked against a last-valid-word / error-count model.
module tb_hf_conf_sched;

  localparam int unsigned G     = 200;
  localparam int unsigned ERR_W = 4;

  logic             clk  = 1'b0;
  logic             rst  = 1'b1;
  logic             spck = 1'b0;
  logic             mosi = 1'b0;
  logic             ncs  = 1'b1;
  logic [7:0]       conf_word;
  logic [2:0]       major_mode;
  logic             switching;
  logic [ERR_W-1:0] frame_err_cnt;

  hf_conf_sched #(
    .GUARD_CYCLES (G),
    .ERR_W        (ERR_W)
  ) dut (
    .ck_1356meg    (clk),
    .rst           (rst),
    .spck          (spck),
    .mosi          (mosi),
    .ncs           (ncs),
    .conf_word     (conf_word),
    .major_mode    (major_mode),
    .switching     (switching),
    .frame_err_cnt (frame_err_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          mon_en = 1'b0;
  bit          mode3_seen = 1'b0;

  typedef struct {
    logic [31:0] data;
    int unsigned nbits;
    logic [7:0]  conf;
    logic [2:0]  major;
    logic [3:0]  err;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Ends on the negedge where ncs rises; the following posedge is edge k.
  task automatic send_frame(input logic [31:0] data, input int unsigned nbits,
                            input int unsigned rst_after);
    ncs = 1'b0;
    tick(2);
    for (int unsigned i = 0; i < nbits; i++) begin
      mosi = data[nbits-1-i];
      tick(2);
      spck = 1'b1;
      tick(2);
      spck = 1'b0;
      if (i + 1 == rst_after) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
    end
    tick(2);
    ncs = 1'b1;
  endtask

  task automatic check_settled(input string name, input logic [7:0] conf,
                               input logic [3:0] err);
    check({name, "_conf"}, 32'(conf_word), 32'(conf));
    check({name, "_major"}, 32'(major_mode), 32'(conf[7:5]));
    check({name, "_err"}, 32'(frame_err_cnt), 32'(err));
    check({name, "_sw"}, 32'(switching), 32'd0);
  endtask

  // Call right after send_frame: measures how long MODE_OFF is held from k+3.
  task automatic measure_guard(input string name);
    int unsigned n = 1;
    int unsigned sw_drop = 0;
    tick(4);
    check({name, "_guard_start_major"}, 32'(major_mode), 32'd7);
    check({name, "_guard_start_sw"}, 32'(switching), 32'd1);
    for (int unsigned c = 0; c < G + 20; c++) begin
      tick(1);
      if (major_mode !== 3'd7) break;
      n++;
      if (switching !== 1'b1) sw_drop++;
    end
    check({name, "_guard_len"}, n, G);
    check({name, "_guard_sw_drops"}, sw_drop, 0);
  endtask

  always @(negedge clk) begin
    if (major_mode === 3'd3) mode3_seen = 1'b1;
    if (mon_en && !rst && !switching)
      check("mode_tracks_conf", 32'(major_mode), 32'(conf_word[7:5]));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached after %0d comparisons", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] model_conf;
    logic [3:0] model_err;

    tbl[0] = '{32'h0000_2055, 15, 8'h80, 3'd4, 4'd1};
    tbl[1] = '{32'h0001_10A3, 17, 8'h80, 3'd4, 4'd2};
    tbl[2] = '{32'h0000_2055, 16, 8'h80, 3'd4, 4'd2};
    tbl[3] = '{32'h0000_1083, 16, 8'h83, 3'd4, 4'd2};
    tbl[4] = '{32'h0000_10E1, 16, 8'hE1, 3'd7, 4'd2};
    tbl[5] = '{32'h0000_0000, 16, 8'hE1, 3'd7, 4'd2};
    tbl[6] = '{32'h0000_1F42, 16, 8'h42, 3'd2, 4'd2};
    tbl[7] = '{32'h0000_0001,  1, 8'h42, 3'd2, 4'd3};

    tick(4);
    rst = 1'b0;
    tick(1);
    check_settled("reset", 8'hE0, 4'd0);
    mon_en = 1'b1;
    tick(5);

    // Guarded change from OFF to mode 1.
    send_frame(32'h1020, 16, 0);
    measure_guard("t1");
    check_settled("t1_final", 8'h20, 4'd0);

    // Same major mode: applied at k+3, no guard.
    send_frame(32'h1023, 16, 0);
    tick(3);
    check("t2_before_k3", 32'(conf_word), 32'h20);
    tick(1);
    check_settled("t2_at_k3", 8'h23, 4'd0);
    begin
      int unsigned sw_seen = 0;
      for (int unsigned c = 0; c < 10; c++) begin
        tick(1);
        if (switching) sw_seen++;
      end
      check("t2_no_switching", sw_seen, 0);
    end

    // Target OFF: applied at k+3 with no guard.
    send_frame(32'h10E0, 16, 0);
    tick(3);
    check("t3_before_k3", 32'(major_mode), 32'd1);
    tick(1);
    check_settled("t3_at_k3", 8'hE0, 4'd0);

    // Guard restart: second word arrives about halfway through the guard.
    mode3_seen = 1'b0;
    send_frame(32'h1060, 16, 0);
    tick(4);
    check("t4_guard1_sw", 32'(switching), 32'd1);
    tick(30);
    send_frame(32'h1080, 16, 0);
    measure_guard("t4");
    check_settled("t4_final", 8'h80, 4'd0);
    check("t4_mode3_never", 32'(mode3_seen), 32'd0);

    // Table of frames with settled expectations.
    for (int unsigned r = 0; r < 8; r++) begin
      send_frame(tbl[r].data, tbl[r].nbits, 0);
      tick(G + 10);
      check($sformatf("tbl%0d_conf", r), 32'(conf_word), 32'(tbl[r].conf));
      check($sformatf("tbl%0d_major", r), 32'(major_mode), 32'(tbl[r].major));
      check($sformatf("tbl%0d_err", r), 32'(frame_err_cnt), 32'(tbl[r].err));
      check($sformatf("tbl%0d_sw", r), 32'(switching), 32'd0);
    end

    // Randomized frames: settled state is the last valid word.
    model_conf = 8'h42;
    model_err  = 4'd3;
    for (int unsigned it = 0; it < 40; it++) begin
      logic [31:0] d;
      int unsigned nb;
      int unsigned r;
      d = $urandom;
      r = $urandom_range(0, 9);
      nb = (r < 7) ? 16 : (r == 7) ? 15 : (r == 8) ? 17 : $urandom_range(1, 14);
      if (nb == 16 && $urandom_range(0, 3) != 0) d[15:12] = 4'b0001;
      if (nb == 16 && d[15:12] == 4'b0001) model_conf = d[7:0];
      else if (nb != 16 && model_err != 4'hF) model_err = model_err + 4'd1;
      send_frame(d, nb, 0);
      if ($urandom_range(0, 2) == 0) begin
        tick(6);
      end else begin
        tick(G + 10);
        check_settled($sformatf("rnd%0d", it), model_conf, model_err);
      end
    end
    tick(G + 10);
    check_settled("rnd_end", model_conf, model_err);

    // Error counter saturation.
    for (int unsigned i = 0; i < 20; i++) begin
      send_frame($urandom, (i % 2 == 0) ? 15 : 8, 0);
      tick(6);
    end
    tick(10);
    check("sat_err", 32'(frame_err_cnt), 32'hF);
    check("sat_conf", 32'(conf_word), 32'(model_conf));

    // Reset after bit 8 of a frame: frame dropped, reset values hold.
    send_frame(32'h1060, 16, 8);
    tick(4);
    check_settled("rstmid_early", 8'hE0, 4'd0);
    tick(G + 10);
    check_settled("rstmid_late", 8'hE0, 4'd0);
    send_frame(32'h1000, 16, 0);
    measure_guard("t6");
    check_settled("t6_final", 8'h00, 4'd0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
